// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for serial_frame_tx: state encoding, counter sizing, line levels.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Frame source handshake plus serial line outputs of serial_frame_tx.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 1,
  parameter int CNT_W = 16
) ();

  logic [NCH*WIDTH-1:0] data;
  logic                 dataValid;
  logic                 dataReady;
  logic                 clockOut;
  logic                 dataOut;
  logic                 frameOut;
  logic [CNT_W-1:0]     frameCount;

  modport master (
    output data, dataValid,
    input  dataReady, clockOut, dataOut, frameOut, frameCount
  );

  modport slave (
    input  data, dataValid,
    output dataReady, clockOut, dataOut, frameOut, frameCount
  );

endinterface

// File: rtl/serial_frame_tx_bit_tick_gen.sv
// Half-bit timer: counts 0..DIV-1, ticks on the last count and toggles the bit-clock phase.
module bit_tick_gen
  import serial_tx_pkg::*;
#(
  parameter int DIV = 4800
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick,
  output logic phase
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg, count_next;
  logic          phase_reg, phase_next;

  assign tick  = (count_reg == LAST);
  assign phase = phase_reg;

  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    if (clr) begin
      count_next = '0;
      phase_next = 1'b0;
    end else if (tick) begin
      count_next = '0;
      phase_next = ~phase_reg;
    end else begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Multi-channel framed serial transmitter with generated bit clock and frame counter.
// Optional even-parity bit after the data when SERIAL_TX_PARITY_EN is defined.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NCH       = 1,
  parameter int DIV       = 4800,
  parameter int IDLE_BITS = 2,
  parameter int CNT_W     = 16
) (
  input logic CLK,
  input logic RST_N,
  serial_frame_tx_if.slave tx
);

  localparam int NBITS = NCH * WIDTH;
  localparam int BW    = cnt_w((NBITS > IDLE_BITS) ? NBITS : IDLE_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(NBITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(IDLE_BITS - 1);

  tx_state_t        state_reg, state_next;
  logic [NBITS-1:0] shift_reg, shift_next, frame_word;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ready_reg;
  logic             accept, tick, phase, bit_end, frame_active, dout;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  // Channel 0 lands in the top bits so the shifter always emits its MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign frame_word[NBITS-1-gi*WIDTH -: WIDTH] = tx.data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (accept),
    .tick  (tick),
    .phase (phase)
  );

  assign bit_end = tick & phase;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    count_next   = count_reg;
    accept       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE:  accept = tx.dataValid & ready_reg;
      START: if (bit_end) state_next = DATA;
      DATA: if (bit_end) begin
        shift_next = shift_reg << 1;
`ifdef SERIAL_TX_PARITY_EN
        parity_next = parity_reg ^ shift_reg[NBITS-1];
`endif
        if (bit_cnt_reg == LAST_DATA) begin
          bit_cnt_next = '0;
`ifdef SERIAL_TX_PARITY_EN
          state_next   = PARITY;
`else
          state_next   = STOP;
`endif
        end else begin
          bit_cnt_next = bit_cnt_reg + BW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: if (bit_end) begin
        if (bit_cnt_reg == LAST_STOP) begin
          count_next = count_reg + CNT_W'(1);
          // A held dataValid is taken on the completion edge: exactly IDLE_BITS gap.
          if (tx.dataValid) accept = 1'b1;
          else state_next = IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      state_next   = START;
      shift_next   = frame_word;
      bit_cnt_next = '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_next  = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      count_reg   <= '0;
      ready_reg   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      count_reg   <= count_next;
      ready_reg   <= (state_next == IDLE);
`ifdef SERIAL_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  assign frame_active = (state_reg == START) || (state_reg == DATA) || (state_reg == PARITY);
`else
  assign frame_active = (state_reg == START) || (state_reg == DATA);
`endif

  always_comb begin
    dout = STOP_LVL;
    case (state_reg)
      START:  dout = START_LVL;
      DATA:   dout = shift_reg[NBITS-1];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: dout = parity_reg;
`endif
      default: dout = STOP_LVL;
    endcase
  end

  assign tx.dataReady  = ready_reg;
  assign tx.clockOut   = phase & frame_active;
  assign tx.dataOut    = dout;
  assign tx.frameOut   = frame_active;
  assign tx.frameCount = count_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx; three instances cover the 8-bit, 2x4-bit DIV=1 and 2-bit counter cases.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FA  = (1 + 8 + P + 2) * 2 * 2;
  localparam int FOA = (1 + 8 + P) * 2 * 2;
  localparam int FOB = (1 + 8 + P) * 2 * 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  serial_frame_tx_if #(.WIDTH(8), .NCH(1), .CNT_W(16)) ifa ();
  serial_frame_tx_if #(.WIDTH(4), .NCH(2), .CNT_W(16)) ifb ();
  serial_frame_tx_if #(.WIDTH(2), .NCH(1), .CNT_W(2))  ifc ();

  serial_frame_tx #(.WIDTH(8), .NCH(1), .DIV(2), .IDLE_BITS(2), .CNT_W(16))
    dut_a (.CLK(CLK), .RST_N(RST_N), .tx(ifa));
  serial_frame_tx #(.WIDTH(4), .NCH(2), .DIV(1), .IDLE_BITS(2), .CNT_W(16))
    dut_b (.CLK(CLK), .RST_N(RST_N), .tx(ifb));
  serial_frame_tx #(.WIDTH(2), .NCH(1), .DIV(1), .IDLE_BITS(1), .CNT_W(2))
    dut_c (.CLK(CLK), .RST_N(RST_N), .tx(ifc));

  int n_checks = 0;
  int n_fail   = 0;

  // dataOut captured at every rising clockOut, newest bit in the LSB
  logic [63:0] got_a = '0, got_b = '0;
  int nb_a = 0, nb_b = 0;
  logic pc_a = 1'b0, pc_b = 1'b0;

  always @(negedge CLK) begin
    if (ifa.clockOut && !pc_a) begin
      got_a = {got_a[62:0], ifa.dataOut};
      nb_a++;
    end
    pc_a = ifa.clockOut;
    if (ifb.clockOut && !pc_b) begin
      got_b = {got_b[62:0], ifb.dataOut};
      nb_b++;
    end
    pc_b = ifb.clockOut;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Append one frame (start + 8 data bits, then parity when built in) to an expected stream.
  function automatic logic [63:0] app(input logic [63:0] acc, input logic [8:0] s, input logic p);
    logic [63:0] r;
    r = {acc[54:0], s};
    if (P == 1) r = {r[62:0], p};
    return r;
  endfunction

  function automatic logic [63:0] last_bits(input logic [63:0] v, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return v & m;
  endfunction

  task automatic wait_ready_a(input string name);
    int t = 0;
    while (!ifa.dataReady && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    check({name, " ready"}, 64'(ifa.dataReady), 64'd1);
  endtask

  logic [15:0] exp_cnt = '0;

  task automatic send_a(input string name, input logic [7:0] d, input logic [8:0] s, input logic p);
    int start, lo, hi;
    wait_ready_a(name);
    start = nb_a;
    ifa.data = d;
    ifa.dataValid = 1'b1;
    @(negedge CLK);
    ifa.dataValid = 1'b0;
    ifa.data = ~d;
    lo = 0;
    hi = 0;
    while (!ifa.dataReady && lo < 1000) begin
      lo++;
      hi += int'(ifa.frameOut);
      @(negedge CLK);
    end
    exp_cnt = exp_cnt + 16'd1;
    check({name, " ready_low"}, 64'(lo), 64'(FA));
    check({name, " frame_high"}, 64'(hi), 64'(FOA));
    check({name, " nbits"}, 64'(nb_a - start), 64'(9 + P));
    check({name, " stream"}, last_bits(got_a, 9 + P), app(64'd0, s, p));
    check({name, " count"}, 64'(ifa.frameCount), 64'(exp_cnt));
    $display("frame %s data=0x%02h bits=0x%0h count=%0d", name, d, last_bits(got_a, 9 + P), ifa.frameCount);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [8:0] stream;
    logic       par;
  } vec_t;

  vec_t vecs[5];
  logic [1:0] cnt_c_exp[5];

  initial begin
    int start, cyc, acc, t, k, bad, hi;
    int t_acc[3];
    logic pf;

    vecs[0] = '{"v_a5", 8'hA5, 9'b1_1010_0101, 1'b0};
    vecs[1] = '{"v_07", 8'h07, 9'b1_0000_0111, 1'b1};
    vecs[2] = '{"v_ff", 8'hFF, 9'b1_1111_1111, 1'b0};
    vecs[3] = '{"v_00", 8'h00, 9'b1_0000_0000, 1'b0};
    vecs[4] = '{"v_80", 8'h80, 9'b1_1000_0000, 1'b1};
    cnt_c_exp[0] = 2'd1; cnt_c_exp[1] = 2'd2; cnt_c_exp[2] = 2'd3;
    cnt_c_exp[3] = 2'd0; cnt_c_exp[4] = 2'd1;

    ifa.data = '0; ifa.dataValid = 1'b0;
    ifb.data = '0; ifb.dataValid = 1'b0;
    ifc.data = '0; ifc.dataValid = 1'b0;

    // reset state and dataReady rising on the first edge with RST_N high
    repeat (3) @(negedge CLK);
    check("rst outputs", {60'd0, ifa.dataReady, ifa.clockOut, ifa.dataOut, ifa.frameOut}, 64'd0);
    check("rst count", 64'(ifa.frameCount), 64'd0);
    RST_N = 1'b1;
    check("rst ready before edge", 64'(ifa.dataReady), 64'd0);
    @(negedge CLK);
    check("rst ready after edge", 64'(ifa.dataReady), 64'd1);

    // back-to-back frames with data changed while each frame is in flight
    wait_ready_a("b2b");
    start = nb_a;
    ifa.data = 8'hA5;
    ifa.dataValid = 1'b1;
    cyc = 0;
    acc = 0;
    pf = 1'b0;
    while (!(acc == 3 && ifa.dataReady) && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (ifa.frameOut && !pf) begin
        t_acc[acc] = cyc;
        acc++;
        case (acc)
          1: ifa.data = 8'h3C;
          2: ifa.data = 8'h07;
          default: begin ifa.dataValid = 1'b0; ifa.data = 8'hFF; end
        endcase
      end
      pf = ifa.frameOut;
    end
    check("b2b accepts", 64'(acc), 64'd3);
    check("b2b gap1", 64'(t_acc[1] - t_acc[0]), 64'(FA));
    check("b2b gap2", 64'(t_acc[2] - t_acc[1]), 64'(FA));
    check("b2b nbits", 64'(nb_a - start), 64'(3 * (9 + P)));
    check("b2b stream", last_bits(got_a, 3 * (9 + P)),
          app(app(app(64'd0, 9'b1_1010_0101, 1'b0), 9'b1_0011_1100, 1'b0), 9'b1_0000_0111, 1'b1));
    check("b2b count", 64'(ifa.frameCount), 64'd3);
    exp_cnt = 16'd3;
    $display("b2b accepts at %0d %0d %0d count=%0d", t_acc[0], t_acc[1], t_acc[2], ifa.frameCount);

    for (int i = 0; i < 5; i++) send_a(vecs[i].name, vecs[i].data, vecs[i].stream, vecs[i].par);

    // one-cycle reset while data bit 3 of 0x5A (a 1) is on the line
    wait_ready_a("midrst");
    ifa.data = 8'h5A;
    ifa.dataValid = 1'b1;
    @(negedge CLK);
    ifa.dataValid = 1'b0;
    repeat (17) @(negedge CLK);
    check("midrst in frame", {62'd0, ifa.frameOut, ifa.dataOut}, 64'd3);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst outputs", {60'd0, ifa.dataReady, ifa.clockOut, ifa.dataOut, ifa.frameOut}, 64'd0);
    check("midrst count", 64'(ifa.frameCount), 64'd0);
    RST_N = 1'b1;
    exp_cnt = '0;
    @(negedge CLK);
    check("midrst ready", 64'(ifa.dataReady), 64'd1);
    send_a("after_rst", 8'hA5, 9'b1_1010_0101, 1'b0);

    // two 4-bit channels at DIV=1: clockOut toggles every cycle of the frame
    t = 0;
    while (!ifb.dataReady && t < 1000) begin @(negedge CLK); t++; end
    check("b ready", 64'(ifb.dataReady), 64'd1);
    start = nb_b;
    ifb.data = 8'h3C;
    ifb.dataValid = 1'b1;
    @(negedge CLK);
    ifb.dataValid = 1'b0;
    ifb.data = 8'h00;
    k = 0; bad = 0; hi = 0;
    while (ifb.frameOut && k < 1000) begin
      if (ifb.clockOut !== k[0]) bad++;
      hi++;
      k++;
      @(negedge CLK);
    end
    check("b clock toggles", 64'(bad), 64'd0);
    check("b frame_high", 64'(hi), 64'(FOB));
    t = 0;
    while (!ifb.dataReady && t < 1000) begin @(negedge CLK); t++; end
    check("b nbits", 64'(nb_b - start), 64'(9 + P));
    check("b stream", last_bits(got_b, 9 + P), app(64'd0, 9'b1_1100_0011, 1'b0));
    check("b count", 64'(ifb.frameCount), 64'd1);
    $display("frame b data=0x3c bits=0x%0h count=%0d", last_bits(got_b, 9 + P), ifb.frameCount);

    // 2-bit frame counter wraps silently
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (!ifc.dataReady && t < 1000) begin @(negedge CLK); t++; end
      ifc.data = 2'(i);
      ifc.dataValid = 1'b1;
      @(negedge CLK);
      ifc.dataValid = 1'b0;
      t = 0;
      while (!ifc.dataReady && t < 1000) begin @(negedge CLK); t++; end
      check($sformatf("c count %0d", i), 64'(ifc.frameCount), 64'(cnt_c_exp[i]));
      $display("frame c%0d count=%0d", i, ifc.frameCount);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
